// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice, LSB first, one bit per clock.
// Results are returned through a start/busy/done handshake.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one operand bit per clock through the adder slice
    // DONE  | result valid for one cycle, start may chain the next op
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             carry;
    logic             c_msb_in;
    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             last_bit;

    assign fa_s     = a_sh[0] ^ b_sh[0] ^ carry;
    assign fa_c     = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    r_sh  <= {fa_s, r_sh[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 2))
                        c_msb_in <= fa_c;
                    if (last_bit) begin
                        sum   <= {fa_s, r_sh[WIDTH-1:1]};
                        cout  <= fa_c;
                        ovf   <= c_msb_in ^ fa_c;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
            // Accepting in DONE overrides the return to IDLE for back-to-back ops.
            if (accept) begin
                a_sh  <= op_a;
                b_sh  <= sub ? ~op_b : op_b;
                carry <= sub ? 1'b1 : cin;
                cnt   <= '0;
                state <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed corner cases plus
// random add/subtract operations against an arithmetic reference model.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int nvec = 0;
    int nerr = 0;
    logic [W-1:0] prev_sum = '0;
    logic [W+1:0] exp_res;
    logic [W-1:0] ra, rb;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
        .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, cout, sum} from plain integer arithmetic and the sign rule.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s, input logic c);
        int unsigned full;
        logic [W-1:0] r;
        logic co, ov;
        if (s) begin
            full = int'(a) + (32'd1 << W) - int'(b);
            ov   = (a[W-1] != b[W-1]);
        end else begin
            full = int'(a) + int'(b) + int'(c);
            ov   = (a[W-1] == b[W-1]);
        end
        r  = full[W-1:0];
        co = full[W];
        ov = ov && (r[W-1] != a[W-1]);
        return {ov, co, r};
    endfunction

    // Called at a negedge: presents a request, returns at the negedge after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c);
        op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
        exp_res = model(a, b, s, c);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done, checking busy/sum stability each RUN cycle; optional start poke mid-run.
    task automatic run_wait(input string tag, input int poke);
        int cyc = 1;
        while (done !== 1'b1 && cyc < 30) begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " sum held"}, 32'(sum), 32'(prev_sum));
            if (cyc == poke) begin
                start = 1'b1; op_a = ~op_a; op_b = ~op_b; sub = ~sub;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 32'(cyc), 32'(W + 1));
        chk({tag, " busy at done"}, 32'(busy), 32'd0);
        chk({tag, " sum"}, 32'(sum), 32'(exp_res[W-1:0]));
        chk({tag, " cout"}, 32'(cout), 32'(exp_res[W]));
        chk({tag, " ovf"}, 32'(ovf), 32'(exp_res[W+1]));
        prev_sum = exp_res[W-1:0];
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input logic c, input int poke);
        launch(a, b, s, c);
        run_wait(tag, poke);
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(done), 32'd0);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        full_op("add5A25", 8'h5A, 8'h25, 1'b0, 1'b0, 0);
        full_op("wrapFF01", 8'hFF, 8'h01, 1'b0, 1'b0, 0);
        full_op("wrapFFcin", 8'hFF, 8'h00, 1'b0, 1'b1, 0);
        full_op("sub10_01", 8'h10, 8'h01, 1'b1, 1'b0, 0);
        full_op("sub01_02", 8'h01, 8'h02, 1'b1, 1'b1, 0);
        full_op("ovf7F01", 8'h7F, 8'h01, 1'b0, 1'b0, 0);
        full_op("ovf80m01", 8'h80, 8'h01, 1'b1, 1'b0, 0);
        full_op("poke", 8'h33, 8'h44, 1'b0, 1'b1, 3);

        // back-to-back: start held through DONE
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        run_wait("b2b first", 0);
        launch(8'hC8, 8'h0F, 1'b1, 1'b0);
        chk("b2b busy rise", 32'(busy), 32'd1);
        chk("b2b done drop", 32'(done), 32'd0);
        chk("b2b sum held", 32'(sum), 32'h46);
        run_wait("b2b second", 0);
        @(negedge clk);
        chk("b2b done pulse", 32'(done), 32'd0);

        // asynchronous reset in the middle of RUN
        launch(8'hAA, 8'h55, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst sum", 32'(sum), 32'd0);
        chk("rst cout", 32'(cout), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst no done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        prev_sum = '0;
        @(negedge clk);
        full_op("post rst", 8'h03, 8'h04, 1'b0, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            full_op("rand", ra, rb, 1'($urandom), 1'($urandom), (i % 5 == 0) ? 2 + (i % 6) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
